// File: rtl/draw_cmd_arbiter.sv
// draw_cmd_arbiter: shares one load/draw engine between N_SRC command stacks.
// A round-robin pick pops one stack, then the arbiter drives load until the
// loader finishes and waits for the drawer before it arbitrates again. A
// watchdog spanning LOAD+DRAW aborts a stalled transaction and moves priority
// past the offending stack, so a stuck stack cannot starve the others.
module draw_cmd_arbiter #(
   parameter int N_SRC   = 4,
   parameter int TIMEOUT = 1000000,
   parameter int CNT_W   = 20,
   parameter int ID_W    = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [N_SRC-1:0] src_empty,
   output logic [N_SRC-1:0] src_pop,
   output logic [ID_W-1:0]  grant_id,
   output logic             load,
   input  logic             load_finish,
   input  logic             draw_finish,
   output logic             busy,
   output logic             timeout_err
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [ID_W-1:0]  last_grant;
   logic [CNT_W-1:0] watchdog;
   logic [N_SRC-1:0] req;
   logic [ID_W:0]    pick_res;
   logic             found;
   logic [ID_W-1:0]  winner;

   // Round-robin search starting just after last_grant. The loop runs from
   // the farthest candidate to the nearest, so the nearest requester is the
   // last one written and wins. Result is {found, index}.
   function automatic logic [ID_W:0] rr_pick(input logic [N_SRC-1:0] r,
                                             input logic [ID_W-1:0]  last);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         idx = (int'(last) + k) % N_SRC;
         if (r[idx]) res = {1'b1, ID_W'(idx)};
      end
      return res;
   endfunction

   // Requests and round-robin winner for the current cycle.
   always_comb begin
      req      = ~src_empty;
      pick_res = rr_pick(req, last_grant);
      found    = pick_res[ID_W];
      winner   = pick_res[ID_W-1:0];
   end

   // Arbitration FSM with registered outputs and the transaction watchdog.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         src_pop     <= '0;
         load        <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         grant_id    <= '0;
         watchdog    <= '0;
         last_grant  <= ID_W'(N_SRC - 1);
      end else begin
         // Pop and timeout are single-cycle pulses.
         src_pop     <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && found) begin
                  grant_id <= winner;
                  src_pop  <= N_SRC'(1) << winner;
                  load     <= 1'b1;
                  busy     <= 1'b1;
                  watchdog <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               // A finish on the limit edge takes precedence over the abort.
               if (load_finish) begin
                  load     <= 1'b0;
                  watchdog <= watchdog + 1'b1;
                  state    <= DRAW;
               end else if (watchdog == WD_LIMIT) begin
                  timeout_err <= 1'b1;
                  load        <= 1'b0;
                  busy        <= 1'b0;
                  last_grant  <= grant_id;
                  state       <= IDLE;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            DRAW: begin
               if (draw_finish) begin
                  busy       <= 1'b0;
                  last_grant <= grant_id;
                  state      <= IDLE;
               end else if (watchdog == WD_LIMIT) begin
                  timeout_err <= 1'b1;
                  load        <= 1'b0;
                  busy        <= 1'b0;
                  last_grant  <= grant_id;
                  state       <= IDLE;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// Testbench for draw_cmd_arbiter (N_SRC=4, TIMEOUT=16): directed scenarios
// with literal expectations plus a transaction-level reference model that is
// compared against the DUT outputs on every falling edge.
module tb_draw_cmd_arbiter;

   localparam int N_SRC   = 4;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;
   localparam int ID_W    = 2;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic [N_SRC-1:0] src_empty = '1;
   logic [N_SRC-1:0] src_pop;
   logic [ID_W-1:0]  grant_id;
   logic             load;
   logic             load_finish = 1'b0;
   logic             draw_finish = 1'b0;
   logic             busy;
   logic             timeout_err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   draw_cmd_arbiter #(
      .N_SRC(N_SRC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .ID_W(ID_W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .src_empty(src_empty),
      .src_pop(src_pop), .grant_id(grant_id), .load(load),
      .load_finish(load_finish), .draw_finish(draw_finish), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   // Reference model: tracks a transaction (granted / loaded / age since grant).
   bit             m_active = 0;
   bit             m_loaded = 0;
   int             m_age    = 0;
   int             m_last   = N_SRC - 1;
   logic [N_SRC-1:0] e_pop  = '0;
   logic           e_load   = 0;
   logic           e_busy   = 0;
   logic           e_to     = 0;
   logic [ID_W-1:0] e_gid   = '0;

   always @(posedge clock) begin
      bit fin;
      int w;
      e_pop = '0;
      e_to  = 1'b0;
      if (reset) begin
         m_active = 0; m_loaded = 0; m_age = 0; m_last = N_SRC - 1;
         e_load = 0; e_busy = 0; e_gid = '0;
      end else if (!m_active) begin
         if (enable && (src_empty != '1)) begin
            w = -1;
            for (int k = 1; k <= N_SRC && w < 0; k++)
               if (!src_empty[(m_last + k) % N_SRC]) w = (m_last + k) % N_SRC;
            m_active = 1; m_loaded = 0; m_age = 0;
            e_gid  = ID_W'(w);
            e_pop  = N_SRC'(1) << w;
            e_load = 1; e_busy = 1;
         end
      end else begin
         m_age++;
         fin = m_loaded ? draw_finish : load_finish;
         if (fin) begin
            if (m_loaded) begin
               e_busy = 0; m_last = int'(e_gid); m_active = 0;
            end else begin
               m_loaded = 1; e_load = 0;
            end
         end else if (m_age == TIMEOUT) begin
            e_to = 1; e_load = 0; e_busy = 0; m_last = int'(e_gid); m_active = 0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clock) begin
      if (cmp_en) begin
         checks++;
         if ({src_pop, load, busy, timeout_err, grant_id} !==
             {e_pop, e_load, e_busy, e_to, e_gid}) begin
            errors++;
            $display("FAIL model_cmp t=%0t: got pop=%b load=%b busy=%b to=%b gid=%0d, need pop=%b load=%b busy=%b to=%b gid=%0d",
                     $time, src_pop, load, busy, timeout_err, grant_id,
                     e_pop, e_load, e_busy, e_to, e_gid);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, need %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Wait (bounded) for the next grant and check which stack won.
   task automatic wait_grant(input int id);
      int n;
      n = 0;
      tick();
      while (!busy && n < 8) begin
         tick();
         n++;
      end
      chk("grant_busy", int'(busy), 1);
      chk("grant_id", int'(grant_id), id);
      chk("grant_pop", int'(src_pop), 1 << id);
   endtask

   task automatic finish_txn();
      load_finish = 1'b1;
      tick();
      load_finish = 1'b0;
      chk("load_drop", int'(load), 0);
      draw_finish = 1'b1;
      tick();
      draw_finish = 1'b0;
      chk("busy_drop", int'(busy), 0);
   endtask

   task automatic serve(input int id);
      wait_grant(id);
      finish_txn();
   endtask

   initial begin
      int cnt;
      int n;
      // Reset state
      tick();
      cmp_en = 1'b1;
      tick();
      chk("rst_pop", int'(src_pop), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_gid", int'(grant_id), 0);
      reset = 1'b0;

      // Single stack 0 transaction
      src_empty = 4'b1110;
      enable    = 1'b1;
      tick();
      chk("t1_pop", int'(src_pop), 4'b0001);
      chk("t1_load", int'(load), 1);
      chk("t1_gid", int'(grant_id), 0);
      chk("t1_busy", int'(busy), 1);
      src_empty = 4'b1111;
      tick();
      chk("t1_pop_clr", int'(src_pop), 0);
      finish_txn();

      // Full round robin after reset: 0,1,2,3,0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      src_empty = 4'b0000;
      serve(0); serve(1); serve(2); serve(3); serve(0);

      // Only stacks 1 and 3 ready: alternate
      src_empty = 4'b0101;
      serve(1); serve(3); serve(1); serve(3);

      // Watchdog abort on stack 2
      src_empty = 4'b1011;
      wait_grant(2);
      src_empty = 4'b0011;
      cnt = 1;
      n = 0;
      while (!timeout_err && n < 40) begin
         tick();
         if (load) cnt++;
         n++;
      end
      chk("to_pulse", int'(timeout_err), 1);
      chk("to_load_cycles", cnt, 16);
      chk("to_busy", int'(busy), 0);
      chk("to_load", int'(load), 0);
      serve(3);

      // draw_finish on the watchdog limit edge completes normally
      src_empty = 4'b1110;
      wait_grant(0);
      src_empty = 4'b1111;
      repeat (4) tick();
      load_finish = 1'b1;
      tick();
      load_finish = 1'b0;
      repeat (10) tick();
      draw_finish = 1'b1;
      tick();
      draw_finish = 1'b0;
      chk("lim_to", int'(timeout_err), 0);
      chk("lim_busy", int'(busy), 0);
      tick();
      chk("lim_to_after", int'(timeout_err), 0);

      // draw_finish during LOAD is ignored
      src_empty = 4'b1101;
      wait_grant(1);
      src_empty = 4'b1111;
      draw_finish = 1'b1;
      tick();
      draw_finish = 1'b0;
      chk("ign_load", int'(load), 1);
      chk("ign_busy", int'(busy), 1);
      finish_txn();

      // Reset while in DRAW, then stack 0 wins
      src_empty = 4'b0000;
      wait_grant(2);
      load_finish = 1'b1;
      tick();
      load_finish = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rd_pop", int'(src_pop), 0);
      chk("rd_load", int'(load), 0);
      chk("rd_busy", int'(busy), 0);
      chk("rd_gid", int'(grant_id), 0);
      serve(0);

      // enable=0 blocks grants; dropping enable mid-LOAD does not abort
      enable = 1'b0;
      repeat (5) begin
         tick();
         chk("dis_pop", int'(src_pop), 0);
         chk("dis_busy", int'(busy), 0);
      end
      enable = 1'b1;
      wait_grant(1);
      enable = 1'b0;
      repeat (3) begin
         tick();
         chk("dis_mid_load", int'(load), 1);
      end
      finish_txn();
      chk("gid_hold", int'(grant_id), 1);
      repeat (3) begin
         tick();
         chk("dis_after", int'(busy), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL global_timeout: got still running, need finished");
      $fatal(1, "bench time limit");
   end

endmodule
